// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-back data cache.
// Widths here are the default geometry (10-bit word address, 32-bit words,
// 32 lines). The controller itself is parametrised and derives its own widths.
package dcache_pkg;

    localparam int BLOCK_SIZE_DEF = 10;
    localparam int DATA_SIZE_DEF  = 32;
    localparam int INDEX_SIZE_DEF = 5;
    localparam int TAG_SIZE_DEF   = BLOCK_SIZE_DEF - INDEX_SIZE_DEF;

    // Controller sequencing: every request passes through LOOKUP; misses
    // optionally write the victim back before filling, then respond.
    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRBACK,
        FILL,
        RESPOND
    } state_e;

    typedef logic [TAG_SIZE_DEF-1:0]   tag_t;
    typedef logic [INDEX_SIZE_DEF-1:0] index_t;
    typedef logic [DATA_SIZE_DEF-1:0]  word_t;
    typedef logic [BLOCK_SIZE_DEF-1:0] addr_t;

    // Upper address bits identify which memory word a line holds.
    function automatic tag_t getTag(input addr_t addr);
        return addr[BLOCK_SIZE_DEF-1:INDEX_SIZE_DEF];
    endfunction

    // Lower address bits select the line.
    function automatic index_t getIndex(input addr_t addr);
        return addr[INDEX_SIZE_DEF-1:0];
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Line storage for the direct-mapped cache: per-line valid, dirty, tag and
// one data word. Single write port, combinational read of the addressed line.
// Valid/dirty clear synchronously on rst; tag and data contents are kept.
module dcache_line_store #(
    parameter int INDEX_SIZE = 5,
    parameter int TAG_SIZE   = 5,
    parameter int DATA_SIZE  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_SIZE-1:0] index,
    input  logic                  wrEn,
    input  logic [TAG_SIZE-1:0]   wrTag,
    input  logic [DATA_SIZE-1:0]  wrData,
    input  logic                  wrDirty,
    output logic                  lineValid,
    output logic                  lineDirty,
    output logic [TAG_SIZE-1:0]   lineTag,
    output logic [DATA_SIZE-1:0]  lineData
);

    localparam int LINES = 1 << INDEX_SIZE;

    logic [LINES-1:0]     validBits;
    logic [LINES-1:0]     dirtyBits;
    logic [TAG_SIZE-1:0]  tagMem  [LINES];
    logic [DATA_SIZE-1:0] dataMem [LINES];

    // Status bits: cleared on reset, a write marks the line valid.
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking (<=) so every flop samples pre-edge values; blocking here creates simulation/synthesis order races.
        if (rst) begin
            validBits <= '0;
            dirtyBits <= '0;
        end else if (wrEn) begin
            validBits[index] <= 1'b1;
            dirtyBits[index] <= wrDirty;
        end
    end

    // Tag and data arrays: written on the single port, never reset.
    always_ff @(posedge clk) begin
        // NOTE: large arrays are deliberately left out of reset; a cleared valid bit already makes their contents unobservable, and a reset would block RAM inference.
        if (wrEn) begin
            tagMem[index]  <= wrTag;
            dataMem[index] <= wrData;
        end
    end

    assign lineValid = validBits[index];
    assign lineDirty = dirtyBits[index];
    assign lineTag   = tagMem[index];
    assign lineData  = dataMem[index];

endmodule

// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// CPU load/store port in front, ready/ack memory handshake behind.
// Optional feature: define DCACHE_STATS_EN to add saturating 32-bit
// hit_cnt/miss_cnt outputs; functional behaviour is identical either way.
module dcache_wb_ctrl
    import dcache_pkg::*;
#(
    parameter int BLOCK_SIZE = 10,
    parameter int DATA_SIZE  = 32,
    parameter int INDEX_SIZE = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_rdEn,
    input  logic                  cpu_wrEn,
    input  logic [BLOCK_SIZE-1:0] cpu_addr,
    input  logic [DATA_SIZE-1:0]  cpu_wrData,
    output logic                  cpu_ready,
    output logic                  cpu_done,
    output logic [DATA_SIZE-1:0]  cpu_rdData,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [BLOCK_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0]  mem_wrData,
    input  logic [DATA_SIZE-1:0]  mem_rdData,
    input  logic                  mem_ack
`ifdef DCACHE_STATS_EN
   ,output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);

    localparam int TAG_SIZE = BLOCK_SIZE - INDEX_SIZE;

    state_e state;
    state_e stateNext;

    // Latched request; only meaningful outside IDLE.
    logic [BLOCK_SIZE-1:0] reqAddr;
    logic [DATA_SIZE-1:0]  reqData;
    logic                  reqStore;

    logic [INDEX_SIZE-1:0] reqIndex;
    logic [TAG_SIZE-1:0]   reqTag;

    logic                  lineValid;
    logic                  lineDirty;
    logic [TAG_SIZE-1:0]   lineTag;
    logic [DATA_SIZE-1:0]  lineData;

    logic                  lsWrEn;
    logic [DATA_SIZE-1:0]  lsWrData;
    logic                  lsWrDirty;

    logic                  hit;
    logic                  accept;

    assign reqIndex = reqAddr[INDEX_SIZE-1:0];
    assign reqTag   = reqAddr[BLOCK_SIZE-1:INDEX_SIZE];
    assign hit      = lineValid && (lineTag == reqTag);
    assign accept   = (state == IDLE) && (cpu_rdEn || cpu_wrEn);

    dcache_line_store #(
        .INDEX_SIZE (INDEX_SIZE),
        .TAG_SIZE   (TAG_SIZE),
        .DATA_SIZE  (DATA_SIZE)
    ) u_lineStore (
        .clk       (clk),
        .rst       (rst),
        .index     (reqIndex),
        .wrEn      (lsWrEn),
        .wrTag     (reqTag),
        .wrData    (lsWrData),
        .wrDirty   (lsWrDirty),
        .lineValid (lineValid),
        .lineDirty (lineDirty),
        .lineTag   (lineTag),
        .lineData  (lineData)
    );

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Capture the request on acceptance; rdEn&wrEn together counts as a store.
    always_ff @(posedge clk) begin
        if (accept) begin
            reqAddr  <= cpu_addr;
            reqData  <= cpu_wrData;
            reqStore <= cpu_wrEn;
        end
    end

    // Next-state, handshake outputs and line-store write control.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned, which would infer a latch.
        stateNext  = state;
        cpu_ready  = 1'b0;
        cpu_done   = 1'b0;
        cpu_rdData = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wrData = '0;
        lsWrEn     = 1'b0;
        lsWrData   = reqData;
        lsWrDirty  = 1'b0;

        // While rst is high every output holds its reset value.
        if (!rst) begin
            case (state)
                IDLE: begin
                    cpu_ready = 1'b1;
                    if (cpu_rdEn || cpu_wrEn) begin
                        stateNext = LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        cpu_done  = 1'b1;
                        stateNext = IDLE;
                        if (reqStore) begin
                            lsWrEn    = 1'b1;
                            lsWrDirty = 1'b1;
                        end else begin
                            cpu_rdData = lineData;
                        end
                    end else if (lineValid && lineDirty) begin
                        stateNext = WRBACK;
                    end else begin
                        stateNext = FILL;
                    end
                end
                WRBACK: begin
                    // Victim line is untouched until the fill, so these stay stable.
                    mem_req    = 1'b1;
                    mem_we     = 1'b1;
                    mem_addr   = {lineTag, reqIndex};
                    mem_wrData = lineData;
                    if (mem_ack) begin
                        stateNext = FILL;
                    end
                end
                FILL: begin
                    mem_req  = 1'b1;
                    mem_addr = reqAddr;
                    if (mem_ack) begin
                        // A store miss merges its word into the fill in one write.
                        lsWrEn    = 1'b1;
                        lsWrData  = reqStore ? reqData : mem_rdData;
                        lsWrDirty = reqStore;
                        stateNext = RESPOND;
                    end
                end
                RESPOND: begin
                    cpu_done  = 1'b1;
                    stateNext = IDLE;
                    if (!reqStore) begin
                        cpu_rdData = lineData;
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // Hit/miss statistics, one count per lookup, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                if (hit_cnt != '1) begin
                    hit_cnt <= hit_cnt + 32'd1;
                end
            end else begin
                if (miss_cnt != '1) begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
        end
    end
`endif

endmodule
